pot_sequencer: RTL and testbench

POT_SEQUENCER -- requirements
Module: pot_sequencer

---
 rtl/pot_sequencer.sv | 174 +++++++++++++++++
 tb/tb_pot_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pot_sequencer.sv
// Pot sweep sequencer: scans six A2D channels, commits all gains on smpl_vld.
// Define POT_AVG_EN to average two back-to-back conversions per slot.
module pot_sequencer #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        smpl_vld,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] LP_gain,
  output logic [11:0] B1_gain,
  output logic [11:0] B2_gain,
  output logic [11:0] B3_gain,
  output logic [11:0] HP_gain,
  output logic [11:0] VOLUME,
  output logic        sweep_done,
  output logic        tmo_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] COMMIT = 3'd4;

  localparam int CMAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ?
                        TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [11:0] UNITY = 12'h800;

  logic [2:0]    state;
  logic [2:0]    idx;
  logic [CW-1:0] cnt;
  logic          abort;
  logic          ph;
  logic [11:0]   shadow [6];
  logic [11:0]   gain [6];
  logic          tmo;
  logic          done;
  logic          first;
  logic          keep;
  logic [11:0]   val;

`ifdef POT_AVG_EN
  logic [11:0] r1;
  logic        t1;
  logic [12:0] sum;

  assign sum   = {1'b0, r1} + {1'b0, res};
  assign first = ~ph;
  assign keep  = t1 | ~cnv_cmplt;
  assign val   = 12'(sum >> 1);
`else
  assign first = 1'b0;
  assign keep  = ~cnv_cmplt;
  assign val   = res;
`endif

  function automatic logic [2:0] chan(input logic [2:0] i);
    case (i)
      3'd0:    chan = 3'd1;
      3'd1:    chan = 3'd0;
      3'd2:    chan = 3'd4;
      3'd3:    chan = 3'd2;
      3'd4:    chan = 3'd3;
      3'd5:    chan = 3'd7;
      default: chan = 3'd0;
    endcase
  endfunction

  // Request is withheld if enable drops in REQ, so no orphan conversion.
  assign strt_cnv = (state == REQ) & enable;
  assign chnnl    = strt_cnv ? chan(idx) : 3'd0;

  assign tmo  = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign done = cnv_cmplt | tmo;

  assign LP_gain = gain[0];
  assign B1_gain = gain[1];
  assign B2_gain = gain[2];
  assign B3_gain = gain[3];
  assign HP_gain = gain[4];
  assign VOLUME  = gain[5];

  always_ff @(posedge clk) begin
    sweep_done <= 1'b0;
    if (rst) begin
      state   <= IDLE;
      idx     <= 3'd0;
      cnt     <= '0;
      abort   <= 1'b0;
      ph      <= 1'b0;
      tmo_err <= 1'b0;
`ifdef POT_AVG_EN
      r1      <= 12'h000;
      t1      <= 1'b0;
`endif
      for (int i = 0; i < 6; i++) begin
        shadow[i] <= UNITY;
        gain[i]   <= UNITY;
      end
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            idx   <= 3'd0;
            ph    <= 1'b0;
            state <= REQ;
          end
        end
        REQ: begin
          if (!enable) begin
            state <= IDLE;
          end else begin
            cnt   <= '0;
            abort <= 1'b0;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (!enable) abort <= 1'b1;
          if (done) begin
            cnt <= '0;
            if (!cnv_cmplt) tmo_err <= 1'b1;
            if (first) begin
              ph <= 1'b1;
`ifdef POT_AVG_EN
              r1 <= res;
              t1 <= ~cnv_cmplt;
`endif
            end else begin
              ph <= 1'b0;
              if (!keep) shadow[idx] <= val;
            end
            if (abort || !enable)
              state <= IDLE;
            else if (!first && idx == 3'd5)
              state <= COMMIT;
            else
              state <= SETTLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SETTLE: begin
          if (!enable) begin
            state <= IDLE;
          end else if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            if (!ph) idx <= idx + 3'd1;
            state <= REQ;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        COMMIT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (smpl_vld) begin
            for (int i = 0; i < 6; i++) gain[i] <= shadow[i];
            sweep_done <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pot_sequencer.sv
// Randomised bench for pot_sequencer: A2D responder plus per-sweep model.
// Builds with or without POT_AVG_EN to match the design.
module tb_pot_sequencer;
  localparam int S = 4;
  localparam int T = 64;
`ifdef POT_AVG_EN
  localparam int NC = 2;
`else
  localparam int NC = 1;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, smpl_vld, cnv_cmplt;
  logic [11:0] res;
  logic        strt_cnv, sweep_done, tmo_err;
  logic [2:0]  chnnl;
  logic [11:0] lp, b1, b2, b3, hp, vol;
  logic [11:0] gv [6];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pot_sequencer #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .enable(enable), .smpl_vld(smpl_vld),
    .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt),
    .res(res), .LP_gain(lp), .B1_gain(b1), .B2_gain(b2),
    .B3_gain(b3), .HP_gain(hp), .VOLUME(vol),
    .sweep_done(sweep_done), .tmo_err(tmo_err)
  );

  assign gv[0] = lp;
  assign gv[1] = b1;
  assign gv[2] = b2;
  assign gv[3] = b3;
  assign gv[4] = hp;
  assign gv[5] = vol;

  int          slot_ch [6] = '{1, 0, 4, 2, 3, 7};
  logic [11:0] va [8];
  logic [11:0] vb [8];
  bit          mute [8];
  int          lat_fix [8];
  logic [11:0] exp_gain [6];
  logic [11:0] exp_shadow [6];
  bit          exp_tmo;
  int          exp_done = 0;
  int          seen_done = 0;

  int          exp_seq [$];
  int          nreq = 0;
  int          cd = 0;
  int          last_cmp = 0;
  int          last_strt = 0;
  bit          pending, armed, prev_mute;
  bit          tgl [8];
  logic [11:0] pval;
  logic [11:0] prev_g [6];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // A2D model: answers each request after a latency, one at a time
  initial begin
    cnv_cmplt = 1'b0;
    res = 12'h000;
    forever begin
      @(negedge clk);
      if (cnv_cmplt) begin
        armed = 1;
        last_cmp = cyc;
      end
      if (strt_cnv) begin
        chk("one_in_flight", 32'(pending), 0);
        if (nreq < exp_seq.size())
          chk("chnnl", 32'(chnnl), exp_seq[nreq]);
        else
          chk("extra_req", nreq, exp_seq.size());
        if (nreq > 0 && armed) chk("settle_gap", cyc - last_cmp, S + 1);
        if (nreq > 0 && prev_mute) chk("tmo_gap", cyc - last_strt, T + S + 1);
        armed = 0;
        prev_mute = mute[chnnl];
        last_strt = cyc;
        nreq++;
        if (!mute[chnnl]) begin
          pending = 1;
          pval = tgl[chnnl] ? vb[chnnl] : va[chnnl];
          tgl[chnnl] = ~tgl[chnnl];
          cd = (lat_fix[chnnl] >= 0) ? lat_fix[chnnl] : int'($urandom_range(0, 7));
        end
      end
      @(posedge clk);
      #1;
      cnv_cmplt = 1'b0;
      if (pending) begin
        if (cd == 0) begin
          cnv_cmplt = 1'b1;
          res = pval;
          pending = 0;
        end else begin
          cd--;
        end
      end
    end
  end

  // Gains may only move in a sweep_done cycle
  initial begin
    forever begin
      @(negedge clk);
      if (!rst)
        for (int k = 0; k < 6; k++)
          if (gv[k] !== prev_g[k]) chk("gain_stable", 32'(sweep_done), 1);
      if (sweep_done === 1'b1) seen_done++;
      prev_g = gv;
    end
  end

  task automatic check_gains(input string tag);
    for (int k = 0; k < 6; k++)
      chk($sformatf("%s_g%0d", tag, k), 32'(gv[k]), 32'(exp_gain[k]));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    enable = 1'b0;
    for (int k = 0; k < 6; k++) begin
      exp_gain[k] = 12'h800;
      exp_shadow[k] = 12'h800;
    end
    exp_tmo = 0;
    repeat (3) @(negedge clk);
    chk("rst_strt", 32'(strt_cnv), 0);
    chk("rst_chnnl", 32'(chnnl), 0);
    chk("rst_done", 32'(sweep_done), 0);
    chk("rst_tmo", 32'(tmo_err), 0);
    check_gains("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_all(input logic [11:0] a, input logic [11:0] b);
    for (int c = 0; c < 8; c++) begin
      va[c] = a;
      vb[c] = b;
    end
  endtask

  task automatic rand_vals();
    for (int c = 0; c < 8; c++) begin
      va[c] = 12'($urandom);
      vb[c] = 12'($urandom);
    end
  endtask

  // Reference: slot value is the (averaged) answer, or unchanged on silence
  task automatic model_sweep();
    for (int k = 0; k < 6; k++) begin
      int c = slot_ch[k];
      if (mute[c]) exp_tmo = 1;
      else if (NC == 2) exp_shadow[k] = 12'((int'(va[c]) + int'(vb[c])) / 2);
      else exp_shadow[k] = va[c];
    end
  endtask

  task automatic start_sweep();
    exp_seq.delete();
    for (int k = 0; k < 6; k++)
      for (int n = 0; n < NC; n++) exp_seq.push_back(slot_ch[k]);
    nreq = 0;
    prev_mute = 0;
    armed = 0;
    for (int c = 0; c < 8; c++) tgl[c] = 0;
    @(posedge clk);
    #1;
    enable = 1'b1;
  endtask

  task automatic wait_reqs(input int n, input bit idle);
    int b = 0;
    while ((nreq < n || (idle && pending)) && b < 3000) begin
      @(negedge clk);
      b++;
    end
    chk("wait_budget", 32'(b < 3000), 1);
  endtask

  task automatic commit(input int hold);
    repeat (hold) @(negedge clk);
    check_gains("pre");
    chk("tmo_err", 32'(tmo_err), 32'(exp_tmo));
    @(posedge clk);
    #1;
    smpl_vld = 1'b1;
    @(posedge clk);
    #1;
    smpl_vld = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    chk("sweep_done", 32'(sweep_done), 1);
    exp_gain = exp_shadow;
    exp_done++;
    check_gains("post");
    @(negedge clk);
    chk("done_pulse", 32'(sweep_done), 0);
  endtask

  task automatic full_sweep(input int hold);
    model_sweep();
    start_sweep();
    wait_reqs(6 * NC, 1);
    commit(hold);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    smpl_vld = 1'b0;
    for (int c = 0; c < 8; c++) begin
      mute[c] = 0;
      lat_fix[c] = -1;
    end
    do_reset();

    set_all(12'hABC, 12'hABC);
    model_sweep();
    start_sweep();
    wait_reqs(2, 0);
    @(posedge clk);
    #1;
    smpl_vld = 1'b1;
    @(posedge clk);
    #1;
    smpl_vld = 1'b0;
    wait_reqs(6 * NC, 1);
    commit(3);

    set_all(12'hABC, 12'hABC);
    va[4] = 12'h100;
    vb[4] = 12'h100;
    full_sweep(500);

    for (int r = 0; r < 3; r++) begin
      rand_vals();
      full_sweep(3 + int'($urandom_range(0, 20)));
    end

    rand_vals();
    lat_fix[0] = T - 1;
    full_sweep(3);
    lat_fix[0] = -1;

    rand_vals();
    mute[2] = 1;
    full_sweep(3);
    mute[2] = 0;

    rand_vals();
    lat_fix[4] = 10;
    start_sweep();
    wait_reqs(2 * NC + 1, 0);
    @(posedge clk);
    #1;
    enable = 1'b0;
    repeat (100) @(negedge clk);
    chk("abort_reqs", nreq, 2 * NC + 1);
    chk("abort_idle", 32'(pending), 0);
    check_gains("abort");
    lat_fix[4] = -1;

    rand_vals();
    lat_fix[1] = 10;
    start_sweep();
    wait_reqs(1, 0);
    do_reset();
    repeat (40) @(negedge clk);
    chk("rst_reqs", nreq, 1);
    chk("rst_tmo_clr", 32'(tmo_err), 0);
    check_gains("rst_mid");
    lat_fix[1] = -1;

    set_all(12'h400, 12'h600);
    full_sweep(3);

    chk("done_count", seen_done, exp_done);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
